picosoc_xbar: RTL

Parametrised NM-master × NS-slave crossbar for the PicoRV32 native memory bus (valid/ready/addr/wdata/wstrb/rdata), replacing the fixed single-master address decode and ready/rdata mux in the SoC top. Each slave window has its own round-robin arbiter, so masters such as the CPU and a DMA engine reach different slaves concurrently. Unmapped accesses and hung slaves complete with an error pulse instead of stalling the bus.

---
 rtl/picosoc_xbar_pkg.sv | 20 ++
 rtl/picosoc_xbar_arb.sv | 86 ++++++++
 rtl/picosoc_xbar.sv | 113 +++++++++++
 3 files changed

// File: rtl/picosoc_xbar_pkg.sv
// Shared constants and helpers for the PicoRV32 native-bus crossbar.
// Imported by the arbiter and the crossbar top.
package picosoc_xbar_pkg;

   typedef logic [31:0] word_t;

   localparam word_t ERR_RDATA = 32'h0000_0000;
   localparam word_t DEF_BASE  = 32'h0000_0000;
   localparam word_t DEF_MASK  = 32'hFFFF_FF00;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/picosoc_xbar_arb.sv
// Per-slave round-robin arbiter: registered one-hot grant, rotating pointer
// and a watchdog that forces completion when the slave never answers.
module picosoc_xbar_arb
   import picosoc_xbar_pkg::*;
#(
   parameter int NM      = 2,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [NM-1:0] req,
   input  logic          ready,
   output logic [NM-1:0] gnt,
   output logic          timeout
);

   localparam int PW = (clog2(NM) < 1) ? 1 : clog2(NM);
   localparam int CW = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);

   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_next;
   logic [PW-1:0] cur;
   logic [PW-1:0] nxt;
   logic [PW-1:0] start;
   logic [PW-1:0] idx;
   logic [PW:0]   sum;
   logic [CW-1:0] cnt;
   logic [NM-1:0] gnt_next;
   logic          busy;
   logic          done;
   logic          pick;
   logic          taken;

   assign busy    = |gnt;
   assign timeout = busy && (TIMEOUT != 0) && (cnt == CW'(TIMEOUT));

   // Next grant: on completion the finishing master is skipped so a waiting
   // master takes the slot immediately; its own next request waits one cycle.
   always_comb begin
      cur = '0;
      for (int i = 0; i < NM; i++) begin
         cur = gnt[i] ? PW'(i) : cur;
      end
      done     = busy & (ready | timeout);
      nxt      = (cur == PW'(NM - 1)) ? '0 : cur + PW'(1);
      start    = done ? nxt : ptr;
      ptr_next = start;
      taken    = 1'b0;
      sum      = '0;
      idx      = '0;
      pick     = 1'b0;
      gnt_next = gnt;
      if (!busy || done) begin
         gnt_next = '0;
         for (int i = 0; i < NM; i++) begin
            sum           = {1'b0, start} + (PW+1)'(i);
            idx           = (sum >= (PW+1)'(NM)) ? PW'(sum - (PW+1)'(NM)) : PW'(sum);
            pick          = req[idx] & ~gnt[idx] & ~taken;
            gnt_next[idx] = pick;
            taken         = taken | pick;
         end
      end else begin
         gnt_next = gnt;
      end
   end

   // Grant, pointer and watchdog registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gnt <= '0;
         ptr <= '0;
         cnt <= '0;
      end else begin
         gnt <= gnt_next;
         ptr <= ptr_next;
         if (!busy || done) begin
            cnt <= '0;
         end else if (cnt != CW'(TIMEOUT)) begin
            cnt <= cnt + CW'(1);
         end else begin
            cnt <= cnt;
         end
      end
   end

endmodule

// File: rtl/picosoc_xbar.sv
// NM-master x NS-slave crossbar for the PicoRV32 native memory bus with
// per-slave round-robin arbitration and an error responder for unmapped addresses.
module picosoc_xbar
   import picosoc_xbar_pkg::*;
#(
   parameter int               NM       = 2,
   parameter int               NS       = 4,
   parameter logic [NS*32-1:0] SLV_BASE = {NS{DEF_BASE}},
   parameter logic [NS*32-1:0] SLV_MASK = {NS{DEF_MASK}},
   parameter int               TIMEOUT  = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NM-1:0]    m_valid,
   input  logic [NM-1:0]    m_instr,
   input  logic [NM*32-1:0] m_addr,
   input  logic [NM*32-1:0] m_wdata,
   input  logic [NM*4-1:0]  m_wstrb,
   output logic [NM-1:0]    m_ready,
   output logic [NM*32-1:0] m_rdata,
   output logic [NM-1:0]    m_err,
   output logic [NS-1:0]    s_valid,
   output logic [NS-1:0]    s_instr,
   output logic [NS*32-1:0] s_addr,
   output logic [NS*32-1:0] s_wdata,
   output logic [NS*4-1:0]  s_wstrb,
   input  logic [NS-1:0]    s_ready,
   input  logic [NS*32-1:0] s_rdata
);

   logic [NM-1:0] req [NS];
   logic [NM-1:0] gnt [NS];
   logic [NS-1:0] timeout;
   logic [NM-1:0] hit;
   logic [NM-1:0] miss;
   logic [NM-1:0] miss_ack;
   logic          match;

   // Address decode; with overlapping windows the lowest slave index wins.
   always_comb begin
      hit   = '0;
      match = 1'b0;
      for (int s = 0; s < NS; s++) begin
         req[s] = '0;
      end
      for (int m = 0; m < NM; m++) begin
         for (int s = 0; s < NS; s++) begin
            match     = (m_addr[m*32 +: 32] & SLV_MASK[s*32 +: 32]) == SLV_BASE[s*32 +: 32];
            req[s][m] = m_valid[m] & ~hit[m] & match;
            hit[m]    = hit[m] | match;
         end
      end
      miss = m_valid & ~hit;
   end

   for (genvar s = 0; s < NS; s++) begin : g_arb
      picosoc_xbar_arb #(
         .NM      (NM),
         .TIMEOUT (TIMEOUT)
      ) u_arb (
         .clk     (clk),
         .reset   (reset),
         .req     (req[s]),
         .ready   (s_ready[s]),
         .gnt     (gnt[s]),
         .timeout (timeout[s])
      );
   end

   // Unmapped access: acknowledge once, one cycle after the request appears.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         miss_ack <= '0;
      end else begin
         miss_ack <= miss & ~miss_ack;
      end
   end

   // Slave-side fan-out from the granted master (grants are one-hot).
   always_comb begin
      s_valid = '0;
      s_instr = '0;
      s_addr  = '0;
      s_wdata = '0;
      s_wstrb = '0;
      for (int s = 0; s < NS; s++) begin
         s_valid[s] = (|gnt[s]) & ~timeout[s];
         for (int m = 0; m < NM; m++) begin
            s_instr[s]          = s_instr[s] | (gnt[s][m] & m_instr[m]);
            s_addr[s*32 +: 32]  = s_addr[s*32 +: 32]  | ({32{gnt[s][m]}} & m_addr[m*32 +: 32]);
            s_wdata[s*32 +: 32] = s_wdata[s*32 +: 32] | ({32{gnt[s][m]}} & m_wdata[m*32 +: 32]);
            s_wstrb[s*4 +: 4]   = s_wstrb[s*4 +: 4]   | ({4{gnt[s][m]}}  & m_wstrb[m*4 +: 4]);
         end
      end
   end

   // Master-side fan-in; s_ready beats a simultaneous watchdog expiry.
   always_comb begin
      m_ready = miss_ack;
      m_err   = miss_ack;
      m_rdata = '0;
      for (int m = 0; m < NM; m++) begin
         m_rdata[m*32 +: 32] = ERR_RDATA;
         for (int s = 0; s < NS; s++) begin
            m_ready[m]          = m_ready[m] | (gnt[s][m] & (s_ready[s] | timeout[s]));
            m_err[m]            = m_err[m] | (gnt[s][m] & timeout[s] & ~s_ready[s]);
            m_rdata[m*32 +: 32] = m_rdata[m*32 +: 32]
                                | ({32{gnt[s][m] & s_ready[s]}} & s_rdata[s*32 +: 32]);
         end
      end
   end

endmodule
